// File: rtl/register_file_pkg.sv
// Shared definitions for the register file: default geometry, the zero-register
// address and the byte-lane merge used by both the write path and the bypass path.
package register_file_pkg;

  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 5;
  localparam int unsigned REG_ZERO       = 0;

  // merge() works on a fixed maximum width; callers zero-extend into it and
  // truncate the result, so DATA_W must not exceed this.
  localparam int unsigned MERGE_MAX_W = 256;

  // Replace each byte lane of old_data whose enable is set with the same lane of new_data.
  function automatic logic [MERGE_MAX_W-1:0] merge(input logic [MERGE_MAX_W-1:0]   old_data,
                                                   input logic [MERGE_MAX_W-1:0]   new_data,
                                                   input logic [MERGE_MAX_W/8-1:0] be);
    logic [MERGE_MAX_W-1:0] res;
    res = old_data;
    for (int i = 0; i < int'(MERGE_MAX_W / 8); i++) begin
      if (be[i]) res[8*i +: 8] = new_data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port of the register file (module regfile_read_port):
// address mux, zero-register masking and, when REGFILE_BYPASS_EN is defined,
// write-through forwarding of the in-flight write.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [DATA_W-1:0]   regs_i [2**ADDR_W],
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic                wr_en_i,
  input  logic                reset_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  output logic [DATA_W-1:0]   rd_data_o
);

`ifndef REGFILE_BYPASS_EN
  // Write-side inputs only matter for forwarding.
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, reset_i, wr_addr_i, wr_data_i, wr_be_i};
`endif

  // Select stored word, optionally forward the pending write, then mask reg 0.
  always_comb begin
    rd_data_o = regs_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_en_i && !reset_i && (rd_addr_i == wr_addr_i)) begin
      rd_data_o = DATA_W'(merge(MERGE_MAX_W'(regs_i[rd_addr_i]), MERGE_MAX_W'(wr_data_i),
                                (MERGE_MAX_W/8)'(wr_be_i)));
    end
`endif
    // Masking last also keeps forwarding off address 0.
    if ((ZERO_REG != 0) && (rd_addr_i == ADDR_W'(REG_ZERO))) rd_data_o = '0;
  end

endmodule

// File: rtl/register_file.sv
// Multi-port MIPS GPR file: NUM_RD combinational read ports and one clocked
// write port with per-byte enables. Optional reg 0 hard-wired to zero.
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     wrEn,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic [DATA_W/8-1:0]      wrByteEn,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wr_commit;

  // Writes to reg 0 are dropped when it is hard-wired; its flops then never change.
  always_comb begin
    wr_commit = wrEn;
    if ((ZERO_REG != 0) && (wrAddr == ADDR_W'(REG_ZERO))) wr_commit = 1'b0;
  end

  // Storage: synchronous clear wins over a simultaneous write.
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
    end else if (wr_commit) begin
      regs_q[wrAddr] <= DATA_W'(merge(MERGE_MAX_W'(regs_q[wrAddr]), MERGE_MAX_W'(wrData),
                                      (MERGE_MAX_W/8)'(wrByteEn)));
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .regs_i   (regs_q),
      .rd_addr_i(rdAddr[p*ADDR_W +: ADDR_W]),
      .wr_en_i  (wrEn),
      .reset_i  (reset),
      .wr_addr_i(wrAddr),
      .wr_data_i(wrData),
      .wr_be_i  (wrByteEn),
      .rd_data_o(rdData[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a ZERO_REG=1 two-port instance and a
// ZERO_REG=0 one-port instance share the write port. Expected read values come
// from two reference arrays and flow through a scoreboard queue.
module tb_register_file;

  logic        Clk = 1'b0;
  logic        reset;
  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrByteEn;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic [4:0]  rdAddr0;
  logic [31:0] rdData0;

  logic [31:0] m1 [32];  // reference for ZERO_REG=1 instance
  logic [31:0] m0 [32];  // reference for ZERO_REG=0 instance
  logic [31:0] sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  register_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .Clk(Clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .wrByteEn(wrByteEn), .rdAddr(rdAddr), .rdData(rdData)
  );

  register_file #(.DATA_W(32), .ADDR_W(5), .NUM_RD(1), .ZERO_REG(0)) dut0 (
    .Clk(Clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .wrByteEn(wrByteEn), .rdAddr(rdAddr0), .rdData(rdData0)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        if (a != 5'd0) m1[a][8*i +: 8] = d[8*i +: 8];
        m0[a][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m1[i] = 32'h0;
      m0[i] = 32'h0;
    end
  endtask

  // One write cycle; inputs change #1 after the edge.
  task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wrEn = 1'b1; wrAddr = a; wrData = d; wrByteEn = be;
    @(posedge Clk); #1;
    wrEn = 1'b0;
    model_write(a, d, be);
  endtask

  // Point the three read ports and queue what they should return.
  task automatic set_reads(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    rdAddr = {a1, a0};
    rdAddr0 = a2;
    sb.push_back(m1[a0]);
    sb.push_back(m1[a1]);
    sb.push_back(m0[a2]);
  endtask

  task automatic test_reset();
    logic [31:0] e, got;
    for (int a = 1; a < 32; a++) drive_write(5'(a), 32'hFFFF_FFFF, 4'hF);
    reset = 1'b1; wrEn = 1'b0;
    @(posedge Clk); #1;
    reset = 1'b0;
    model_clear();
    for (int a = 0; a < 32; a++) begin
      set_reads(5'(a), 5'(31 - a), 5'(a));
      #1;
      for (int k = 0; k < 3; k++) begin
        e = sb.pop_front();
        got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL reset port%0d addr %0d: got %h expected %h", k, a, got, e);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e, got;
    drive_write(5'd5, 32'hFFFF_FF22, 4'hF);
    set_reads(5'd5, 5'd5, 5'd5);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
      n_cmp++;
      if (got !== e || e !== 32'hFFFF_FF22) begin
        n_err++;
        $display("FAIL write_read port%0d: got %h expected %h", k, got, 32'hFFFF_FF22);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] e, got;
    drive_write(5'd5, 32'hBB44_AA11, 4'b1010);
    set_reads(5'd5, 5'd5, 5'd5);
    #1;
    // enables set but no lanes selected: nothing may change
    drive_write(5'd5, 32'h0000_0000, 4'b0000);
    set_reads(5'd5, 5'd5, 5'd5);
    #1;
    for (int k = 0; k < 6; k++) begin
      e = sb.pop_front();
      got = ((k % 3) < 2) ? rdData[(k % 3)*32 +: 32] : rdData0;
      n_cmp++;
      if (got !== 32'hBBFF_AA22 || e !== 32'hBBFF_AA22) begin
        n_err++;
        $display("FAIL byte_lanes step%0d: got %h expected %h", k, got, 32'hBBFF_AA22);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] e, got;
    drive_write(5'd0, 32'h1623_FF22, 4'hF);
    set_reads(5'd0, 5'd0, 5'd0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h1623_FF22);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL zero_reg_model port%0d: got %h expected %h", k, got, e);
      end
    end
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL zero_reg_const port%0d: got %h expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_reset_vs_write();
    logic [31:0] e, got;
    drive_write(5'd7, 32'h1234_5678, 4'hF);
    reset = 1'b1;
    wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'hFFAA_FF22; wrByteEn = 4'hF;
    @(posedge Clk); #1;
    reset = 1'b0; wrEn = 1'b0;
    model_clear();
    set_reads(5'd7, 5'd5, 5'd7);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL reset_vs_write port%0d: got %h expected %h", k, got, e);
      end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e, got;
    logic        byp;
`ifdef REGFILE_BYPASS_EN
    byp = 1'b1;
`else
    byp = 1'b0;
`endif
    // Full-word write to r9 (currently 0), observed before the edge.
    wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'hBB44_FF22; wrByteEn = 4'hF;
    rdAddr = {5'd9, 5'd9}; rdAddr0 = 5'd9;
    for (int k = 0; k < 3; k++) sb.push_back(byp ? 32'hBB44_FF22 : 32'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL bypass_pre port%0d: got %h expected %h", k, got, e);
      end
    end
    @(posedge Clk); #1;
    wrEn = 1'b0;
    model_write(5'd9, 32'hBB44_FF22, 4'hF);
    set_reads(5'd9, 5'd9, 5'd9);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL bypass_post port%0d: got %h expected %h", k, got, e);
      end
    end
    // Partial lane forwarding; port 1 reads an unrelated address.
    wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h0000_0011; wrByteEn = 4'b0001;
    rdAddr = {5'd5, 5'd9}; rdAddr0 = 5'd9;
    sb.push_back(byp ? 32'hBB44_FF11 : 32'hBB44_FF22);
    sb.push_back(m1[5]);
    sb.push_back(byp ? 32'hBB44_FF11 : 32'hBB44_FF22);
    // Address 0: never forwarded on the hard-wired instance.
    #1;
    wrAddr = 5'd0; wrData = 32'h1357_9BDF; wrByteEn = 4'hF;
    rdAddr = {5'd0, 5'd0}; rdAddr0 = 5'd0;
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(byp ? 32'h1357_9BDF : m0[0]);
    // Reset held: no forwarding, stored value shows.
    #1;
    wrAddr = 5'd9; wrData = 32'h0; reset = 1'b1;
    rdAddr = {5'd9, 5'd9}; rdAddr0 = 5'd9;
    for (int k = 0; k < 3; k++) sb.push_back(32'hBB44_FF22);
    #1;
    reset = 1'b0; wrEn = 1'b0;
    // Replay the three settings to compare in queue order.
    for (int s = 0; s < 3; s++) begin
      wrEn = 1'b1; reset = (s == 2);
      wrAddr = (s == 1) ? 5'd0 : 5'd9;
      wrData = (s == 0) ? 32'h0000_0011 : ((s == 1) ? 32'h1357_9BDF : 32'h0);
      wrByteEn = (s == 0) ? 4'b0001 : 4'hF;
      rdAddr = (s == 0) ? {5'd5, 5'd9} : {wrAddr, wrAddr};
      rdAddr0 = wrAddr;
      #1;
      for (int k = 0; k < 3; k++) begin
        e = sb.pop_front();
        got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL bypass_case%0d port%0d: got %h expected %h", s, k, got, e);
        end
      end
    end
    reset = 1'b0; wrEn = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, got;
    logic [4:0]  a;
    for (int n = 0; n < 60; n++) begin
      a = 5'($urandom_range(0, 31));
      drive_write(a, $urandom, 4'($urandom_range(0, 15)));
      set_reads(a, 5'($urandom_range(0, 31)), (n % 2 == 0) ? a : 5'($urandom_range(0, 31)));
      #1;
      for (int k = 0; k < 3; k++) begin
        e = sb.pop_front();
        got = (k < 2) ? rdData[k*32 +: 32] : rdData0;
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL back_to_back iter%0d port%0d: got %h expected %h", n, k, got, e);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0; wrByteEn = '0;
    rdAddr = '0; rdAddr0 = '0;
    model_clear();
    @(posedge Clk); #1;
    reset = 1'b0;
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_zero_reg();
    test_reset_vs_write();
    test_bypass();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
